// File: rtl/seq_div_restoring.sv
// Iterative unsigned restoring divider producing one quotient bit per clock.
// Optional DIV_ZERO_EARLY_EN: a zero divisor finishes on the accepting edge instead of iterating.
module seq_div_restoring #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Adder with 4-bit lookahead blocks; block carries ripple, the top bit is a plain sum.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH:0] a,
                                             input logic [WIDTH:0] b,
                                             input logic           cin);
    logic [WIDTH:0] g;
    logic [WIDTH:0] p;
    logic [WIDTH:0] c;
    int             base;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int blk = 0; blk < WIDTH / 4; blk++) begin
      base = blk * 4;
      c[base+1] = g[base] | (p[base] & c[base]);
      c[base+2] = g[base+1] | (p[base+1] & g[base]) | (p[base+1] & p[base] & c[base]);
      c[base+3] = g[base+2] | (p[base+2] & g[base+1]) | (p[base+2] & p[base+1] & g[base])
                | (p[base+2] & p[base+1] & p[base] & c[base]);
      c[base+4] = g[base+3] | (p[base+3] & g[base+2]) | (p[base+3] & p[base+2] & g[base+1])
                | (p[base+3] & p[base+2] & p[base+1] & g[base])
                | (p[base+3] & p[base+2] & p[base+1] & p[base] & c[base]);
    end
    return p ^ c;
  endfunction

  // The restored partial remainder is always below the divisor, so its bit WIDTH is
  // provably zero and only WIDTH bits are stored; the shifted value regains the extra bit.
  assign p_sh  = {p_q, q_q[WIDTH-1]};
  assign trial = cla_add(p_sh, ~{1'b0, d_q}, 1'b1);
  assign p_nxt = trial[WIDTH] ? p_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nxt = {q_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          p_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_ZERO_EARLY_EN
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        p_d   = p_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = q_nxt;
          rem_d   = p_nxt;
          dbz_d   = (d_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_restoring.sv
// Directed bench for seq_div_restoring at WIDTH=8 with hand-computed expected results.
module tb_seq_div_restoring;

  localparam int WIDTH = 8;
`ifdef DIV_ZERO_EARLY_EN
  localparam int ZERO_LAT  = 0;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = WIDTH;
  localparam int ZERO_BUSY = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_div_restoring #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat = number of edges after the accepting edge before done is seen (-1 on timeout).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic edz, input int elat, input logic ebusy);
    int lat;
    launch(a, b);
    check({tag, "_busy0"}, 32'(busy), 32'(ebusy));
    wait_done(lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_quo"}, 32'(quotient), 32'(eq));
    check({tag, "_rem"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quo", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_vec("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, WIDTH, 1'b1);
    run_vec("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, WIDTH, 1'b1);
    run_vec("d3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, WIDTH, 1'b1);
    run_vec("d77_0", 8'd77, 8'd0, 8'd255, 8'd77, 1'b1, ZERO_LAT, ZERO_BUSY[0]);
    run_vec("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, WIDTH, 1'b1);
    run_vec("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, WIDTH, 1'b1);
    run_vec("d128_3", 8'd128, 8'd3, 8'd42, 8'd2, 1'b0, WIDTH, 1'b1);
    run_vec("d255_16", 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, WIDTH, 1'b1);
    run_vec("d0_0", 8'd0, 8'd0, 8'd255, 8'd0, 1'b1, ZERO_LAT, ZERO_BUSY[0]);
    run_vec("d200_9", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, WIDTH, 1'b1);

    // start pulses while iterating must not disturb the running divide
    launch(8'd100, 8'd7);
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (i == 2 || i == 5 || i == 7) begin
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("ign_lat", lat, WIDTH);
    check("ign_quo", 32'(quotient), 32'd14);
    check("ign_rem", 32'(remainder), 32'd2);

    // back-to-back: start issued during the done cycle
    dividend = 8'd200;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    check("b2b_quo_held", 32'(quotient), 32'd14);
    wait_done(lat);
    check("b2b_lat", lat, WIDTH);
    check("b2b_quo", 32'(quotient), 32'd22);
    check("b2b_rem", 32'(remainder), 32'd2);
    @(posedge clk);
    #1;
    check("hold_done", 32'(done), 32'd0);
    check("hold_quo", 32'(quotient), 32'd22);
    check("hold_rem", 32'(remainder), 32'd2);

    // reset during iteration aborts the divide
    launch(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quo", 32'(quotient), 32'd0);
    check("abort_rem", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_vec("post_rst", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, WIDTH, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
